// File: rtl/sync_fifo_pkg.sv
// Shared types for the single-clock event FIFO.
// Encodes which FIFO operations were accepted on a given cycle.
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage for sync_fifo: one synchronous write port and one registered read port.
// The array itself is never reset so it can map onto block RAM.
module sync_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value whenever no read is accepted.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and registered empty/full flags.
// Carries overflow/underflow event records from the producer block to the bus interface.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  wr_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              wr_acc;
    logic              rd_acc;
    fifo_op_e          op;

    always_comb begin
        // A full FIFO still accepts a write when a read frees a slot in the same cycle.
        wr_acc   = wr_en & (~full_q | rd_en);
        rd_acc   = rd_en & ~empty_q;
        op       = fifo_op_e'({rd_acc, wr_acc});
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_W'(1);
        end

        case (op)
            OP_WRITE: count_d = count_q + CNT_W'(1);
            OP_READ:  count_d = count_q - CNT_W'(1);
            default:  count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (reset),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DATA_WIDTH=9, DEPTH=16).
module tb_sync_fifo;

    logic       clk;
    logic       reset;
    logic [8:0] data_in;
    logic       rd_en;
    logic       wr_en;
    logic [8:0] data_out;
    logic       empty;
    logic       full;

    int unsigned n_cmp;
    int unsigned n_bad;

    sync_fifo #(
        .DATA_WIDTH (9),
        .DEPTH      (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic rd, input logic wr, input logic [8:0] d);
        rd_en   = rd;
        wr_en   = wr;
        data_in = d;
        @(posedge clk);
        #1;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        data_in = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        data_in = '0;

        // 1. reset state and read while empty
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(data_out), 32'h0);
        step(1'b1, 1'b0, 9'h0);
        chk("rd_empty_dout", 32'(data_out), 32'h0);
        chk("rd_empty_empty", 32'(empty), 32'd1);

        // 2. single push/pop
        step(1'b0, 1'b1, 9'h1A5);
        chk("push1_empty", 32'(empty), 32'd0);
        chk("push1_dout_hold", 32'(data_out), 32'h0);
        step(1'b1, 1'b0, 9'h0);
        chk("pop1_dout", 32'(data_out), 32'h1A5);
        chk("pop1_empty", 32'(empty), 32'd1);

        // 3. fill, overflow attempt, drain
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 9'(i));
            if (i == 14) chk("fill15_full", 32'(full), 32'd0);
        end
        chk("fill16_full", 32'(full), 32'd1);
        chk("fill_dout_hold", 32'(data_out), 32'h1A5);
        step(1'b0, 1'b1, 9'h1FF);
        chk("ovf_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 9'h0);
            chk($sformatf("drain%0d", i), 32'(data_out), 32'(i));
            if (i == 0) chk("drain_full_clr", 32'(full), 32'd0);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step(1'b1, 1'b1, 9'h000);
        step(1'b1, 1'b0, 9'h0);
        chk("unf_ignored_dout", 32'(data_out), 32'h000);
        step(1'b1, 1'b0, 9'h0);
        chk("unf_hold_dout", 32'(data_out), 32'h000);

        // 4. pointer wrap: six rounds of push 3 / pop 3
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 9'(9'h040 + 9'(r * 3 + k)));
            for (int k = 0; k < 3; k++) begin
                step(1'b1, 1'b0, 9'h0);
                chk($sformatf("wrap_r%0d_k%0d", r, k), 32'(data_out), 32'(9'h040 + 9'(r * 3 + k)));
            end
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // 5. simultaneous read/write when full and when empty
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 9'(9'h100 + 9'(i)));
        step(1'b1, 1'b1, 9'h055);
        chk("rw_full_full", 32'(full), 32'd1);
        chk("rw_full_dout", 32'(data_out), 32'h100);
        for (int i = 1; i < 16; i++) begin
            step(1'b1, 1'b0, 9'h0);
            chk($sformatf("rw_drain%0d", i), 32'(data_out), 32'(9'h100 + 9'(i)));
        end
        step(1'b1, 1'b0, 9'h0);
        chk("rw_last_dout", 32'(data_out), 32'h055);
        chk("rw_last_empty", 32'(empty), 32'd1);
        step(1'b1, 1'b1, 9'h0AA);
        chk("rw_empty_dout", 32'(data_out), 32'h055);
        chk("rw_empty_empty", 32'(empty), 32'd0);
        step(1'b1, 1'b0, 9'h0);
        chk("rw_empty_pop", 32'(data_out), 32'h0AA);

        // 6. asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 9'(9'h011 + 9'(i)));
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_dout", 32'(data_out), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 1'b1, 9'h0C3);
        step(1'b1, 1'b0, 9'h0);
        chk("post_rst_dout", 32'(data_out), 32'h0C3);
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
